video_dma_control_mc: RTL and testbench

- Multi-channel, parametrised successor to the video board's DMA control block.
- Per channel: CPU byte writes (low byte, then high bits plus a command) load a transfer length. The channel then issues LEN+1 transfer grants, one per enabled pixel slot. While active, EXCT[ch] is raised.
- Adds over the single-channel design: NCH channels with round-robin arbitration, auto-reload (repeat) mode, a stop command, a stall input, and per-channel done pulses.
- Sits between the CPU data-bus decode (XY write strobes) and the video RAM address/transfer sequencer.

---
 rtl/video_dma_control_mc.sv | 122 ++++++++++++
 tb/tb_video_dma_control_mc.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/video_dma_control_mc.sv
// Multi-channel video DMA length sequencer: CPU-loaded per-channel transfer counts,
// round-robin slot grants, optional auto-reload, stop command and stall gating.
module video_dma_control_mc #(
    parameter int NCH   = 2,
    parameter int CNT_W = 12,
    parameter int DBW   = 8,
    parameter int CHW   = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic           CLK,
    input  logic           RST,
    input  logic           WR_LO,
    input  logic           WR_HI,
    input  logic [CHW-1:0] WR_CH,
    input  logic [DBW-1:0] DB,
    input  logic           SLOT_EN,
    input  logic           STALL,
    output logic [NCH-1:0] EXCT,
    output logic           EXCT_ANY,
    output logic           XFER,
    output logic [CHW-1:0] XFER_CH,
    output logic [NCH-1:0] DONE
);

    localparam int HIW = CNT_W - DBW;

    logic [CNT_W-1:0] len_q    [NCH];
    logic [CNT_W-1:0] len_next [NCH];
    logic [CNT_W-1:0] rem_q    [NCH];
    logic [NCH-1:0]   auto_q;
    logic [NCH-1:0]   exct_q;
    logic [NCH-1:0]   wr_sel;
    logic [NCH-1:0]   grant_hit;
    logic [CHW-1:0]   last_q;
    logic [CHW-1:0]   grant_ch;
    logic             grant;

    // Out-of-range channel numbers select nothing, so such writes are dropped.
    always_comb begin
        for (int ch = 0; ch < NCH; ch++) begin
            wr_sel[ch]   = (int'(WR_CH) == ch);
            len_next[ch] = len_q[ch];
            if (WR_LO && wr_sel[ch]) begin
                len_next[ch][DBW-1:0] = DB;
            end
            if (WR_HI && wr_sel[ch]) begin
                len_next[ch][CNT_W-1:DBW] = DB[HIW-1:0];
            end
        end
    end

    // Round-robin: first active channel strictly after the last granted one.
    always_comb begin
        logic found;
        int   idx;
        found    = 1'b0;
        idx      = 0;
        grant_ch = '0;
        for (int i = 1; i <= NCH; i++) begin
            idx = (int'(last_q) + i) % NCH;
            if (!found && exct_q[idx]) begin
                found    = 1'b1;
                grant_ch = CHW'(idx);
            end
        end
    end

    assign grant = SLOT_EN & ~STALL & (|exct_q);

    always_comb begin
        for (int ch = 0; ch < NCH; ch++) begin
            grant_hit[ch] = grant && (grant_ch == CHW'(ch));
            DONE[ch]      = grant_hit[ch] && (rem_q[ch] == '0);
        end
    end

    assign EXCT     = exct_q;
    assign EXCT_ANY = |exct_q;
    assign XFER     = grant;
    assign XFER_CH  = grant ? grant_ch : '0;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            for (int ch = 0; ch < NCH; ch++) begin
                len_q[ch] <= '0;
                rem_q[ch] <= '0;
            end
            auto_q <= '0;
            exct_q <= '0;
            last_q <= CHW'(NCH - 1);
        end else begin
            if (grant) begin
                last_q <= grant_ch;
            end
            for (int ch = 0; ch < NCH; ch++) begin
                len_q[ch] <= len_next[ch];
                if (grant_hit[ch]) begin
                    if (rem_q[ch] == '0) begin
                        if (auto_q[ch]) begin
                            rem_q[ch] <= len_q[ch];
                        end else begin
                            exct_q[ch] <= 1'b0;
                        end
                    end else begin
                        rem_q[ch] <= rem_q[ch] - CNT_W'(1);
                    end
                end
                // A command write overrides whatever the same-cycle grant did.
                if (WR_HI && wr_sel[ch]) begin
                    if (DB[DBW-2]) begin
                        exct_q[ch] <= 1'b0;
                        auto_q[ch] <= 1'b0;
                    end else begin
                        exct_q[ch] <= 1'b1;
                        auto_q[ch] <= DB[DBW-1];
                        rem_q[ch]  <= len_next[ch];
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_video_dma_control_mc.sv
// Directed self-checking bench for video_dma_control_mc (NCH=2, CNT_W=12, DBW=8).
module tb_video_dma_control_mc;

    localparam int NCH = 2;
    localparam int CHW = 1;

    logic           CLK;
    logic           RST;
    logic           WR_LO;
    logic           WR_HI;
    logic [CHW-1:0] WR_CH;
    logic [7:0]     DB;
    logic           SLOT_EN;
    logic           STALL;
    logic [NCH-1:0] EXCT;
    logic           EXCT_ANY;
    logic           XFER;
    logic [CHW-1:0] XFER_CH;
    logic [NCH-1:0] DONE;

    int checks = 0;
    int errors = 0;

    video_dma_control_mc #(
        .NCH  (NCH),
        .CNT_W(12),
        .DBW  (8)
    ) dut (
        .CLK     (CLK),
        .RST     (RST),
        .WR_LO   (WR_LO),
        .WR_HI   (WR_HI),
        .WR_CH   (WR_CH),
        .DB      (DB),
        .SLOT_EN (SLOT_EN),
        .STALL   (STALL),
        .EXCT    (EXCT),
        .EXCT_ANY(EXCT_ANY),
        .XFER    (XFER),
        .XFER_CH (XFER_CH),
        .DONE    (DONE)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "bench timeout");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset();
        RST = 1'b1;
        tick();
        RST = 1'b0;
    endtask

    task automatic wr_lo(input int ch, input logic [7:0] d);
        WR_CH = CHW'(ch);
        DB    = d;
        WR_LO = 1'b1;
        tick();
        WR_LO = 1'b0;
    endtask

    task automatic wr_hi(input int ch, input logic [7:0] d);
        WR_CH = CHW'(ch);
        DB    = d;
        WR_HI = 1'b1;
        tick();
        WR_HI = 1'b0;
    endtask

    // Runs ch0 with SLOT_EN high until it goes idle; optional low-byte write at cycle lo_at.
    task automatic run_count(input int lo_at, output int cnt, output int dones, output int done_at);
        cnt     = 0;
        dones   = 0;
        done_at = 0;
        SLOT_EN = 1'b1;
        WR_CH   = '0;
        for (int c = 0; c < 5000 && EXCT[0]; c++) begin
            WR_LO = (c == lo_at);
            DB    = 8'h05;
            #1;
            if (XFER) cnt++;
            if (DONE[0]) begin
                dones++;
                done_at = cnt;
            end
            tick();
        end
        WR_LO   = 1'b0;
        SLOT_EN = 1'b0;
    endtask

    initial begin
        int cnt;
        int dones;
        int done_at;
        logic [CHW-1:0] seq_ch [5];
        logic [NCH-1:0] seq_dn [5];
        seq_ch = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        seq_dn = '{2'b00, 2'b00, 2'b00, 2'b10, 2'b01};

        RST = 1'b1; WR_LO = 1'b0; WR_HI = 1'b0; WR_CH = '0; DB = '0;
        SLOT_EN = 1'b0; STALL = 1'b0;
        #12;
        check("rst_exct", 32'(EXCT), 0);
        check("rst_exct_any", 32'(EXCT_ANY), 0);
        check("rst_done", 32'(DONE), 0);
        SLOT_EN = 1'b1;
        #1;
        check("rst_xfer", 32'(XFER), 0);
        check("rst_xfer_ch", 32'(XFER_CH), 0);
        SLOT_EN = 1'b0;
        tick();
        RST = 1'b0;

        // Single channel, LEN=3 -> 4 grants
        wr_lo(0, 8'h03);
        wr_hi(0, 8'h00);
        check("t1_exct_start", 32'(EXCT), 32'h1);
        check("t1_exct_any", 32'(EXCT_ANY), 1);
        SLOT_EN = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            check("t1_xfer", 32'(XFER), 1);
            check("t1_xfer_ch", 32'(XFER_CH), 0);
            check("t1_done", 32'(DONE), (i == 3) ? 32'h1 : 32'h0);
            tick();
        end
        check("t1_exct_end", 32'(EXCT), 0);
        check("t1_xfer_end", 32'(XFER), 0);
        SLOT_EN = 1'b0;

        // Two channels interleaved
        do_reset();
        wr_lo(0, 8'h02);
        wr_hi(0, 8'h00);
        wr_lo(1, 8'h01);
        wr_hi(1, 8'h00);
        check("t2_exct", 32'(EXCT), 32'h3);
        SLOT_EN = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1;
            check("t2_xfer", 32'(XFER), 1);
            check("t2_xfer_ch", 32'(XFER_CH), 32'(seq_ch[i]));
            check("t2_done", 32'(DONE), 32'(seq_dn[i]));
            tick();
        end
        check("t2_exct_end", 32'(EXCT), 0);
        SLOT_EN = 1'b0;

        // Auto-reload on ch1, then stop
        wr_lo(1, 8'h01);
        wr_hi(1, 8'h80);
        SLOT_EN = 1'b1;
        for (int i = 0; i < 6; i++) begin
            #1;
            check("t3_xfer", 32'(XFER), 1);
            check("t3_xfer_ch", 32'(XFER_CH), 1);
            check("t3_done", 32'(DONE), (i % 2 == 1) ? 32'h2 : 32'h0);
            check("t3_exct", 32'(EXCT), 32'h2);
            tick();
        end
        SLOT_EN = 1'b0;
        wr_hi(1, 8'h40);
        check("t3_exct_stop", 32'(EXCT), 0);
        SLOT_EN = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("t3_no_xfer", 32'(XFER), 0);
            tick();
        end
        SLOT_EN = 1'b0;

        // Stall mid-transfer
        wr_lo(0, 8'h03);
        wr_hi(0, 8'h00);
        SLOT_EN = 1'b1;
        for (int i = 0; i < 2; i++) begin
            #1;
            check("t4_pre_xfer", 32'(XFER), 1);
            check("t4_pre_done", 32'(DONE), 0);
            tick();
        end
        STALL = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1;
            check("t4_stall_xfer", 32'(XFER), 0);
            check("t4_stall_done", 32'(DONE), 0);
            tick();
        end
        STALL = 1'b0;
        for (int i = 0; i < 2; i++) begin
            #1;
            check("t4_post_xfer", 32'(XFER), 1);
            check("t4_post_done", 32'(DONE), (i == 1) ? 32'h1 : 32'h0);
            tick();
        end
        check("t4_exct_end", 32'(EXCT), 0);
        SLOT_EN = 1'b0;

        // Max length with a low-byte write during the run
        wr_lo(0, 8'hFF);
        wr_hi(0, 8'h0F);
        run_count(100, cnt, dones, done_at);
        check("t5_grants", 32'(cnt), 4096);
        check("t5_dones", 32'(dones), 1);
        check("t5_done_at", 32'(done_at), 4096);
        wr_hi(0, 8'h00);
        run_count(-1, cnt, dones, done_at);
        check("t5_restart_grants", 32'(cnt), 6);
        check("t5_restart_done_at", 32'(done_at), 6);

        // Asynchronous reset mid-transfer
        do_reset();
        wr_lo(0, 8'h03);
        wr_hi(0, 8'h00);
        SLOT_EN = 1'b1;
        tick();
        tick();
        #2;
        RST = 1'b1;
        #1;
        check("t6_exct", 32'(EXCT), 0);
        check("t6_exct_any", 32'(EXCT_ANY), 0);
        check("t6_xfer", 32'(XFER), 0);
        check("t6_done", 32'(DONE), 0);
        SLOT_EN = 1'b0;
        tick();
        RST = 1'b0;
        wr_hi(1, 8'h00);
        wr_lo(0, 8'h00);
        wr_hi(0, 8'h00);
        SLOT_EN = 1'b1;
        #1;
        check("t6_last_first", 32'(XFER_CH), 0);
        tick();
        check("t6_last_second", 32'(XFER_CH), 1);
        SLOT_EN = 1'b0;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
